video_card: RTL and testbench



---
 rtl/video_card_if.sv | 23 ++
 rtl/video_card.sv | 184 ++++++++++++++++++
 tb/tb_video_card.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_card_if.sv
// Video RAM port bundle: the engine masters the single-port RAM.
interface video_card_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] address;
    logic             wren;

    modport master (
        input  data_in,
        output data_out,
        output address,
        output wren
    );

    modport slave (
        output data_in,
        input  data_out,
        input  address,
        input  wren
    );
endinterface

// File: rtl/video_card.sv
// Command-list driven fill/copy engine, sole master of a single-port
// synchronous video RAM (2-cycle reads, 1-cycle writes).
module video_card #(
    parameter int          WIDTH    = 32,
    parameter int unsigned CMD_BASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    video_card_if.master  bus
);
    localparam int CW = WIDTH - 4;

    localparam logic [3:0] OP_FILL = 4'h1;
    localparam logic [3:0] OP_COPY = 4'h2;
    localparam logic [3:0] OP_JUMP = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] THREE   = WIDTH'(3);

    typedef enum logic [2:0] {
        HDR,
        ARG1,
        ARG2,
        FILL_WR,
        COPY_RD,
        COPY_WR,
        HALT
    } state_t;

    state_t           state_q, state_d;
    logic             ph_q, ph_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] a2_q, a2_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wren_q, wren_d;

    logic [3:0]    hdr_op;
    logic [CW-1:0] hdr_cnt;

    assign hdr_op  = bus.data_in[WIDTH-1 -: 4];
    assign hdr_cnt = bus.data_in[CW-1:0];

    // ph_q: 0 = address presented, 1 = read data valid on data_in
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pc_d    = pc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        wren_d  = 1'b0;

        unique case (state_q)
            HDR: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    op_d  = hdr_op;
                    cnt_d = hdr_cnt;
                    if (hdr_op == OP_HALT) begin
                        state_d = HALT;
                    end else if (hdr_op == OP_FILL || hdr_op == OP_COPY ||
                                 hdr_op == OP_JUMP) begin
                        state_d = ARG1;
                        addr_d  = pc_q + ONE;
                    end else begin
                        pc_d   = pc_q + ONE;
                        addr_d = pc_q + ONE;
                    end
                end
            end
            ARG1: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    a1_d = bus.data_in;
                    if (op_q == OP_JUMP) begin
                        state_d = HDR;
                        pc_d    = bus.data_in;
                        addr_d  = bus.data_in;
                    end else begin
                        state_d = ARG2;
                        addr_d  = pc_q + TWO;
                    end
                end
            end
            ARG2: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    a2_d = bus.data_in;
                    pc_d = pc_q + THREE;
                    if (cnt_q == '0) begin
                        state_d = HDR;
                        addr_d  = pc_q + THREE;
                    end else if (op_q == OP_FILL) begin
                        state_d = FILL_WR;
                        addr_d  = a1_q;
                        dout_d  = bus.data_in;
                        wren_d  = 1'b1;
                    end else begin
                        state_d = COPY_RD;
                        addr_d  = a1_q;
                    end
                end
            end
            FILL_WR: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = HDR;
                    addr_d  = pc_q;
                end else begin
                    addr_d = addr_q + ONE;
                    wren_d = 1'b1;
                end
            end
            COPY_RD: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    state_d = COPY_WR;
                    dout_d  = bus.data_in;
                    addr_d  = a2_q;
                    wren_d  = 1'b1;
                end
            end
            COPY_WR: begin
                cnt_d = cnt_q - CNT_ONE;
                a1_d  = a1_q + ONE;
                a2_d  = a2_q + ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = HDR;
                    addr_d  = pc_q;
                end else begin
                    state_d = COPY_RD;
                    addr_d  = a1_q + ONE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HDR;
                ph_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR;
            ph_q    <= 1'b0;
            pc_q    <= WIDTH'(CMD_BASE);
            op_q    <= '0;
            cnt_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            addr_q  <= WIDTH'(CMD_BASE);
            dout_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wren_q  <= wren_d;
        end
    end

    assign bus.address  = addr_q;
    assign bus.data_out = dout_q;
    assign bus.wren     = wren_q;
endmodule

// File: tb/tb_video_card.sv
// Bench for video_card: RAM model, command-list interpreter that predicts
// the full per-cycle bus trace, and directed programs.
module tb_video_card;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load = 1'b0;
    bit   active = 1'b0;
    int   hreq = 0;

    int cyc = 0;
    int wr_seen = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] init [256];
    logic [31:0] ram  [256];

    bit          exp_wren [MAXC];
    logic [31:0] exp_addr [MAXC];
    logic [31:0] exp_data [MAXC];
    int          halt_cyc;
    int          nwr;

    video_card_if #(.WIDTH(32)) bus ();

    video_card #(.WIDTH(32), .CMD_BASE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init[i];
        end else begin
            bus.data_in <= ram[bus.address[7:0]];
            if (bus.wren) ram[bus.address[7:0]] <= bus.data_out;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    // Predicted bus trace: reads cost 2 cycles, writes 1 cycle
    task automatic mrd(input int t, input logic [31:0] a);
        if (t + 1 < MAXC) begin
            exp_addr[t]     = a;
            exp_addr[t + 1] = a;
        end
    endtask

    task automatic mwr(input int t, input logic [31:0] a,
                       input logic [31:0] d);
        if (t < MAXC) begin
            exp_wren[t] = 1'b1;
            exp_addr[t] = a;
            exp_data[t] = d;
        end
        nwr++;
    endtask

    task automatic build_model();
        logic [31:0] m [256];
        logic [31:0] pc, h, a1, a2, p1, p2, sa, da;
        int t, n;
        bit done;
        for (int i = 0; i < 256; i++) m[i] = init[i];
        for (int c = 0; c < MAXC; c++) begin
            exp_wren[c] = 1'b0;
            exp_addr[c] = 32'h0;
            exp_data[c] = 32'h0;
        end
        nwr = 0;
        halt_cyc = 0;
        done = 1'b0;
        t = 1;
        pc = 32'h0;
        for (int s = 0; s < 64 && !done; s++) begin
            h = m[pc[7:0]];
            mrd(t, pc);
            t += 2;
            p1 = pc + 32'd1;
            p2 = pc + 32'd2;
            case (h[31:28])
                4'hF: begin
                    done = 1'b1;
                    halt_cyc = t;
                    for (int c = t; c < MAXC; c++) exp_addr[c] = pc;
                end
                4'h3: begin
                    mrd(t, p1);
                    t += 2;
                    pc = m[p1[7:0]];
                end
                4'h1, 4'h2: begin
                    a1 = m[p1[7:0]];
                    a2 = m[p2[7:0]];
                    mrd(t, p1);
                    mrd(t + 2, p2);
                    t += 4;
                    n = int'(h[27:0]);
                    for (int i = 0; i < n; i++) begin
                        if (h[31:28] == 4'h1) begin
                            da = a1 + 32'(i);
                            mwr(t, da, a2);
                            m[da[7:0]] = a2;
                            t += 1;
                        end else begin
                            sa = a1 + 32'(i);
                            da = a2 + 32'(i);
                            mrd(t, sa);
                            t += 2;
                            mwr(t, da, m[sa[7:0]]);
                            m[da[7:0]] = m[sa[7:0]];
                            t += 1;
                        end
                    end
                    pc = pc + 32'd3;
                end
                default: pc = pc + 32'd1;
            endcase
        end
    endtask

    // Sole compare process: per-cycle trace check plus literal checks
    always @(negedge clk) begin
        int c;
        if (!active) begin
            cyc = 0;
            wr_seen = 0;
        end else begin
            cyc++;
            c = (cyc < MAXC) ? cyc : MAXC - 1;
            chk("wren", 32'(bus.wren), 32'(exp_wren[c]));
            chk("addr", bus.address, exp_addr[c]);
            if (exp_wren[c]) chk("data", bus.data_out, exp_data[c]);
            if (bus.wren) wr_seen++;
        end
        case (hreq)
            1: begin
                for (int i = 0; i < 4; i++)
                    chk("t1_mem", ram[8'h40 + i], 32'hDEADBEEF);
                chk("t1_halt_cyc", 32'(halt_cyc), 32'd13);
                chk("t6_hold_wren", 32'(bus.wren), 32'd0);
                chk("t6_hold_addr", bus.address, 32'h3);
                chk("t1_nwr", 32'(wr_seen), 32'd4);
            end
            2: begin
                chk("t2_mem90", ram[8'h90], 32'h11);
                chk("t2_mem91", ram[8'h91], 32'h22);
                chk("t2_w9", exp_wren[9] ? exp_addr[9] : 32'hFFFF, 32'h90);
                chk("t2_w12", exp_wren[12] ? exp_addr[12] : 32'hFFFF, 32'h91);
                chk("t2_nwr", 32'(wr_seen), 32'd2);
            end
            3: begin
                chk("t3_nwr", 32'(wr_seen), 32'd0);
                chk("t3_model_nwr", 32'(nwr), 32'd0);
                chk("t3_halt_cyc", 32'(halt_cyc), 32'd11);
                chk("t3_addr", bus.address, 32'h4);
            end
            4: begin
                chk("t4_mem20", ram[8'h20], 32'h7);
                chk("t4_nwr", 32'(wr_seen), 32'd1);
                chk("t4_halt_cyc", 32'(halt_cyc), 32'd14);
                chk("t4_addr", bus.address, 32'h13);
            end
            5: begin
                chk("t5_rst_wren", 32'(bus.wren), 32'd0);
                chk("t5_rst_addr", bus.address, 32'h0);
            end
            6: begin
                chk("t5_nwr", 32'(wr_seen), 32'd4);
                chk("t5_mem43", ram[8'h43], 32'hDEADBEEF);
                chk("t5_addr", bus.address, 32'h3);
            end
            default: ;
        endcase
    end

    task automatic clear_init();
        for (int i = 0; i < 256; i++) init[i] = 32'h0;
    endtask

    task automatic start();
        active = 1'b0;
        reset = 1'b1;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        active = 1'b1;
    endtask

    task automatic hand(input int k);
        hreq = k;
        @(negedge clk);
        #1 hreq = 0;
    endtask

    task automatic run(input int n, input int k);
        start();
        wait (cyc >= n);
        #1 hand(k);
        active = 1'b0;
    endtask

    initial begin
        bus.data_in = 32'h0;
        repeat (2) @(posedge clk);

        // FILL 4 words then HALT; long tail covers halt hold
        clear_init();
        init[0] = 32'h10000004;
        init[1] = 32'h40;
        init[2] = 32'hDEADBEEF;
        init[3] = 32'hF0000000;
        build_model();
        run(120, 1);

        // COPY 2 words
        clear_init();
        init[0] = 32'h20000002;
        init[1] = 32'h80;
        init[2] = 32'h90;
        init[3] = 32'hF0000000;
        init[8'h80] = 32'h11;
        init[8'h81] = 32'h22;
        build_model();
        run(30, 2);

        // FILL N=0, unknown opcode, HALT
        clear_init();
        init[0] = 32'h10000000;
        init[3] = 32'h50000000;
        init[4] = 32'hF0000000;
        build_model();
        run(30, 3);

        // JUMP to a FILL N=1
        clear_init();
        init[0] = 32'h30000000;
        init[1] = 32'h10;
        init[8'h10] = 32'h10000001;
        init[8'h11] = 32'h20;
        init[8'h12] = 32'h7;
        init[8'h13] = 32'hF0000000;
        build_model();
        run(30, 4);

        // Reset pulsed mid-fill, fill restarts from header 0
        clear_init();
        init[0] = 32'h10000004;
        init[1] = 32'h40;
        init[2] = 32'hDEADBEEF;
        init[3] = 32'hF0000000;
        build_model();
        start();
        wait (cyc >= 7);
        @(posedge clk);
        #1 reset = 1'b1;
        active = 1'b0;
        @(posedge clk);
        #1 hand(5);
        @(posedge clk);
        #1 reset = 1'b0;
        active = 1'b1;
        wait (cyc >= 20);
        #1 hand(6);
        active = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
